// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// All outputs come from registers; Q_n is the complement of the registered line.
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] D,
  input  logic              load,
  output logic              ready,
  output logic              Q,
  output logic              Q_n
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IdxW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              parity_q;
  logic              q_q;
  logic              ready_q;

  logic bit_done;
  assign bit_done = (cnt_q == CntLast);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      q_q      <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            shift_q  <= D;
            parity_q <= ^D;
            state_q  <= StStart;
            q_q      <= 1'b0;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
          end
        end
        StStart: begin
          if (bit_done) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= StData;
            q_q     <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (idx_q == IdxLast) begin
              if (PARITY_EN) begin
                state_q <= StParity;
                q_q     <= parity_q;
              end else begin
                state_q <= StStop;
                q_q     <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              q_q     <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StParity: begin
          if (bit_done) begin
            cnt_q   <= '0;
            state_q <= StStop;
            q_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_done) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          q_q     <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign Q     = q_q;
  assign Q_n   = ~q_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: three instances cover plain, parity and one-cycle-per-bit
// configurations; every cycle each line and ready flag is compared with a queued expectation.
module tb_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic [7:0] d_a, d_p;
  logic [3:0] d_c;
  logic       load_a, load_p, load_c;
  logic       q_a, qn_a, rdy_a;
  logic       q_p, qn_p, rdy_p;
  logic       q_c, qn_c, rdy_c;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_a (
    .clk(clk), .clr(clr), .D(d_a), .load(load_a), .ready(rdy_a), .Q(q_a), .Q_n(qn_a)
  );
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_p (
    .clk(clk), .clr(clr), .D(d_p), .load(load_p), .ready(rdy_p), .Q(q_p), .Q_n(qn_p)
  );
  serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_c (
    .clk(clk), .clr(clr), .D(d_c), .load(load_c), .ready(rdy_c), .Q(q_c), .Q_n(qn_c)
  );

  typedef struct packed {
    logic q;
    logic rdy;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_p[$];
  exp_t exp_c[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_exp(input int inst, input exp_t e);
    case (inst)
      0:       exp_a.push_back(e);
      1:       exp_p.push_back(e);
      default: exp_c.push_back(e);
    endcase
  endtask

  // One entry per clock cycle of the frame, then the single ready cycle that follows the stop bit.
  task automatic push_frame(input int inst, input logic [15:0] data, input int dw, input int cpb,
                            input bit par);
    logic bits[$];
    logic p;
    exp_t e;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      bits.push_back(data[i]);
      p = p ^ data[i];
    end
    if (par) bits.push_back(p);
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < cpb; k++) begin
        e.q   = bits[i];
        e.rdy = 1'b0;
        push_exp(inst, e);
      end
    end
    e.q   = 1'b1;
    e.rdy = 1'b1;
    push_exp(inst, e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    exp_t ea, ep, ec;
    ea = '{q: 1'b1, rdy: 1'b1};
    ep = '{q: 1'b1, rdy: 1'b1};
    ec = '{q: 1'b1, rdy: 1'b1};
    if (exp_a.size() > 0) ea = exp_a.pop_front();
    if (exp_p.size() > 0) ep = exp_p.pop_front();
    if (exp_c.size() > 0) ec = exp_c.pop_front();
    check("a_q", q_a, ea.q);
    check("a_ready", rdy_a, ea.rdy);
    check("a_qn", qn_a, !q_a);
    check("p_q", q_p, ep.q);
    check("p_ready", rdy_p, ep.rdy);
    check("p_qn", qn_p, !q_p);
    check("c_q", q_c, ec.q);
    check("c_ready", rdy_c, ec.rdy);
    check("c_qn", qn_c, !q_c);
  end

  initial begin
    clr    = 1'b0;
    d_a    = '0;
    d_p    = '0;
    d_c    = '0;
    load_a = 1'b0;
    load_p = 1'b0;
    load_c = 1'b0;
    #1 clr = 1'b1;
    #1;
    check("rst_a_q", q_a, 1'b1);
    check("rst_a_qn", qn_a, 1'b0);
    check("rst_a_ready", rdy_a, 1'b1);
    check("rst_p_q", q_p, 1'b1);
    check("rst_c_ready", rdy_c, 1'b1);
    wait_cycles(2);
    clr = 1'b0;
    wait_cycles(2);

    // Plain frame; D changes right after acceptance.
    d_a = 8'hA5; load_a = 1'b1;
    wait_cycles(1);
    load_a = 1'b0; d_a = 8'h00;
    push_frame(0, 16'h00A5, 8, 4, 1'b0);
    wait_cycles(44);

    // Parity frames: 0x07 carries parity 1, 0x03 carries parity 0.
    d_p = 8'h07; load_p = 1'b1;
    wait_cycles(1);
    load_p = 1'b0;
    push_frame(1, 16'h0007, 8, 4, 1'b1);
    wait_cycles(47);
    d_p = 8'h03; load_p = 1'b1;
    wait_cycles(1);
    load_p = 1'b0;
    push_frame(1, 16'h0003, 8, 4, 1'b1);
    wait_cycles(47);

    // One clock per bit.
    d_c = 4'b1001; load_c = 1'b1;
    wait_cycles(1);
    load_c = 1'b0;
    push_frame(2, 16'h0009, 4, 1, 1'b0);
    wait_cycles(10);

    // Load held high across two frames: second start follows the ready cycle at once.
    d_a = 8'h00; load_a = 1'b1;
    wait_cycles(1);
    push_frame(0, 16'h0000, 8, 4, 1'b0);
    d_a = 8'hFF;
    wait_cycles(41);
    load_a = 1'b0;
    push_frame(0, 16'h00FF, 8, 4, 1'b0);
    wait_cycles(44);

    // Load pulsed mid-frame must be dropped entirely.
    d_a = 8'h5A; load_a = 1'b1;
    wait_cycles(1);
    load_a = 1'b0;
    push_frame(0, 16'h005A, 8, 4, 1'b0);
    wait_cycles(9);
    d_a = 8'h3C; load_a = 1'b1;
    wait_cycles(1);
    load_a = 1'b0;
    wait_cycles(40);

    // Asynchronous clear during data bit 3, with load held through the clear.
    d_a = 8'hC3; load_a = 1'b1;
    wait_cycles(1);
    load_a = 1'b0;
    push_frame(0, 16'h00C3, 8, 4, 1'b0);
    wait_cycles(17);
    clr = 1'b1;
    #1;
    check("clr_a_q", q_a, 1'b1);
    check("clr_a_qn", qn_a, 1'b0);
    check("clr_a_ready", rdy_a, 1'b1);
    exp_a.delete();
    d_a = 8'h81; load_a = 1'b1;
    wait_cycles(2);
    #0 clr = 1'b0;
    wait_cycles(1);
    load_a = 1'b0;
    push_frame(0, 16'h0081, 8, 4, 1'b0);
    wait_cycles(46);

    check("a_drained", exp_a.size() == 0, 1'b1);
    check("p_drained", exp_p.size() == 0, 1'b1);
    check("c_drained", exp_c.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
